// File: rtl/beep_detect.sv
// Beep burst receiver: measures half-periods of a synchronized beep line, classifies them as
// HI/LO tone, counts segments and pulses done/err when the line goes silent. Option: BEEP_DETECT_STRICT_EN.
module beep_detect #(
  parameter int HP_HI      = 8,
  parameter int HP_LO      = 16,
  parameter int TOL        = 2,
  parameter int MIN_SEG_HP = 4,
  parameter int SIL_CYC    = 64,
  parameter int NUM_SEG    = 4,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beep_in,
  output logic       tone_active,
  output logic       tone_hi,
  output logic [2:0] seg_cnt,
  output logic       done,
  output logic       err
);

  localparam logic [CW-1:0] HI_MIN  = CW'(HP_HI - TOL);
  localparam logic [CW-1:0] HI_MAX  = CW'(HP_HI + TOL);
  localparam logic [CW-1:0] LO_MIN  = CW'(HP_LO - TOL);
  localparam logic [CW-1:0] LO_MAX  = CW'(HP_LO + TOL);
  localparam logic [CW-1:0] SIL     = CW'(SIL_CYC);
  localparam logic [CW-1:0] MIN_SEG = CW'(MIN_SEG_HP);
  localparam logic [CW-1:0] HP_ONE  = CW'(1);
  localparam logic [2:0]    NSEG    = 3'(NUM_SEG);

  typedef enum logic [2:0] {IDLE, FIRST, MEAS, DONE, ERR} state_t;

  state_t        state;
  logic          sync1, sync2, sync3;
  logic          sync_edge;
  logic          silent;
  logic [CW-1:0] hp_cnt;
  logic [CW-1:0] seg_hp;
  logic          cur_class;
  logic          is_hi, is_lo, is_bad;
  logic          first_ok;
  logic [2:0]    seg_inc;

  // sync1/sync2 resynchronize the pin; sync3 is the previous sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= beep_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign sync_edge = sync2 ^ sync3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hp_cnt <= '0;
    else if (sync_edge)
      hp_cnt <= '0;
    else if (hp_cnt != SIL)
      hp_cnt <= hp_cnt + HP_ONE;
  end

  assign is_hi   = (hp_cnt >= HI_MIN) && (hp_cnt <= HI_MAX);
  assign is_lo   = (hp_cnt >= LO_MIN) && (hp_cnt <= LO_MAX);
  assign is_bad  = !is_hi && !is_lo;
  assign silent  = !sync_edge && (hp_cnt == SIL);
  assign seg_inc = seg_cnt + 3'd1;

`ifdef BEEP_DETECT_STRICT_EN
  assign first_ok = is_hi;
`else
  assign first_ok = is_hi || is_lo;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tone_active <= 1'b0;
      tone_hi     <= 1'b0;
      seg_cnt     <= 3'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      cur_class   <= 1'b0;
      seg_hp      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (sync_edge) begin
            state       <= FIRST;
            tone_active <= 1'b1;
            seg_cnt     <= 3'd0;
          end else begin
            state <= IDLE;
          end
        end
        // A lone edge followed by silence is treated as a malformed burst
        FIRST: begin
          if (sync_edge) begin
            if (!first_ok) begin
              state       <= ERR;
              err         <= 1'b1;
              tone_active <= 1'b0;
            end else begin
              cur_class <= is_hi;
              tone_hi   <= is_hi;
              seg_hp    <= HP_ONE;
              state     <= MEAS;
            end
          end else if (silent) begin
            state       <= ERR;
            err         <= 1'b1;
            tone_active <= 1'b0;
          end
        end
        MEAS: begin
          if (sync_edge) begin
            if (is_bad) begin
              state       <= ERR;
              err         <= 1'b1;
              tone_active <= 1'b0;
            end else if (is_hi == cur_class) begin
              if (seg_hp != '1)
                seg_hp <= seg_hp + HP_ONE;
            end else if (seg_hp < MIN_SEG) begin
              state       <= ERR;
              err         <= 1'b1;
              tone_active <= 1'b0;
            end else begin
              seg_cnt <= seg_inc;
              if (seg_inc == NSEG) begin
                state       <= ERR;
                err         <= 1'b1;
                tone_active <= 1'b0;
              end else begin
                cur_class <= is_hi;
                tone_hi   <= is_hi;
                seg_hp    <= HP_ONE;
              end
            end
          end else if (silent) begin
            if (seg_hp >= MIN_SEG)
              seg_cnt <= seg_inc;
            tone_active <= 1'b0;
            if ((seg_hp >= MIN_SEG) && (seg_inc == NSEG)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        // Any edge clears hp_cnt, so the line must stay quiet a full SIL_CYC before re-arming
        ERR: begin
          if (silent)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beep_detect.sv
// Self-checking bench for beep_detect: table-driven bursts, hand-written reset sequence,
// and randomized bursts judged by a run-length reference model.
module tb_beep_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       beep_in;
  logic       tone_active;
  logic       tone_hi;
  logic [2:0] seg_cnt;
  logic       done;
  logic       err;

  localparam int HI_LOW  = 8 - 2;
  localparam int HI_HIGH = 8 + 2;
  localparam int LO_LOW  = 16 - 2;
  localparam int LO_HIGH = 16 + 2;
  localparam int MIN_SEG = 4;
  localparam int NUM_SEG = 4;
  localparam int SIL     = 64;
  // pin toggle -> pulse: 2 sync stages + edge register, then SIL counts + registered pulse
  localparam int EDGE_LAT = 3;
  localparam int SIL_LAT  = SIL + 4;
`ifdef BEEP_DETECT_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef struct packed {
    int nseg;
    int l0, l1, l2, l3, l4;
    bit first_hi;
    int ha, hb, la, lb;
    int bad_idx, bad_hp;
    bit exp_done, exp_err;
    int exp_seg, exp_at;
    bit chk_hi;
  } vec_t;

  always #5 clk = ~clk;

  beep_detect dut (
    .clk        (clk),
    .rst        (rst),
    .beep_in    (beep_in),
    .tone_active(tone_active),
    .tone_hi    (tone_hi),
    .seg_cnt    (seg_cnt),
    .done       (done),
    .err        (err)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, done_cyc = 0, err_cyc = 0;
  int hi_log[$];
  int tgl[$];
  logic last_hi = 1'b0;

  always @(posedge clk) cyc++;

  // Pulse and tone-class monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (done && err) both_cnt++;
    if (tone_active && (tone_hi != last_hi)) hi_log.push_back(int'(tone_hi));
    last_hi = tone_hi;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Each list entry is a measured half-period: the pin toggles hp+1 cycles after the previous toggle
  task automatic applyStimulus(input int hps[$]);
    @(posedge clk); #1 beep_in = ~beep_in; tgl.push_back(cyc);
    foreach (hps[i]) begin
      repeat (hps[i] + 1) @(posedge clk);
      #1 beep_in = ~beep_in;
      tgl.push_back(cyc);
    end
  endtask

  function automatic int classOf(input int hp);
    if (hp >= HI_LOW && hp <= HI_HIGH) return 1;
    if (hp >= LO_LOW && hp <= LO_HIGH) return 0;
    return 2;
  endfunction

  // Reference: split the half-period list into runs of equal tone and apply the burst rules.
  // at = index of the half-period whose edge raises err, -2 = err on silence, -1 = no err
  task automatic judge(input int hps[$], output bit ed, output bit ee, output int es, output int at);
    int run_cls, run_len, c;
    ed = 0; ee = 0; es = 0; at = -1; run_cls = -1; run_len = 0;
    for (int i = 0; i < hps.size(); i++) begin
      c = classOf(hps[i]);
      if (c == 2 || (i == 0 && STRICT && c == 0)) begin ee = 1; at = i; return; end
      if (i == 0 || c == run_cls) begin
        run_cls = c;
        run_len++;
      end else begin
        if (run_len < MIN_SEG) begin ee = 1; at = i; return; end
        es++;
        if (es == NUM_SEG) begin ee = 1; at = i; return; end
        run_cls = c;
        run_len = 1;
      end
    end
    if (run_len >= MIN_SEG) es++;
    if (run_len >= MIN_SEG && es == NUM_SEG) ed = 1;
    else begin ee = 1; at = -2; end
  endtask

  task automatic runBurst(input string tag, input int hps[$], input bit ed, input bit ee,
                          input int es, input int at, output int log0);
    int d0, e0;
    tgl.delete();
    d0 = done_cnt; e0 = err_cnt; log0 = hi_log.size();
    applyStimulus(hps);
    repeat (5) @(posedge clk); #1;
    checkOutput({tag, " active_at_end"}, int'(tone_active), (ee && at >= 0) ? 0 : 1);
    repeat (200) @(posedge clk); #1;
    checkOutput({tag, " done_pulses"}, done_cnt - d0, int'(ed));
    checkOutput({tag, " err_pulses"}, err_cnt - e0, int'(ee));
    checkOutput({tag, " seg_cnt"}, int'(seg_cnt), es);
    checkOutput({tag, " active_idle"}, int'(tone_active), 0);
    if (ed && done_cnt != d0) checkOutput({tag, " done_time"}, done_cyc - tgl[$], SIL_LAT);
    if (ee && err_cnt != e0) begin
      if (at >= 0) checkOutput({tag, " err_time"}, err_cyc - tgl[at + 1], EDGE_LAT);
      else         checkOutput({tag, " err_time"}, err_cyc - tgl[$], SIL_LAT);
    end
  endtask

  function automatic vec_t mk(input int nseg, input int l0, input int l1, input int l2,
                              input int l3, input int l4, input bit fh, input int ha,
                              input int hb, input int la, input int lb, input int bi,
                              input int bh, input bit ed, input bit ee, input int es,
                              input int at, input bit ch);
    vec_t v;
    v.nseg = nseg; v.l0 = l0; v.l1 = l1; v.l2 = l2; v.l3 = l3; v.l4 = l4;
    v.first_hi = fh; v.ha = ha; v.hb = hb; v.la = la; v.lb = lb;
    v.bad_idx = bi; v.bad_hp = bh; v.exp_done = ed; v.exp_err = ee;
    v.exp_seg = es; v.exp_at = at; v.chk_hi = ch;
    return v;
  endfunction

  function automatic int segLen(input vec_t v, input int s);
    case (s)
      0: return v.l0;
      1: return v.l1;
      2: return v.l2;
      3: return v.l3;
      default: return v.l4;
    endcase
  endfunction

  task automatic buildBurst(input vec_t v, output int q[$]);
    bit hi;
    int hp;
    q.delete();
    for (int s = 0; s < v.nseg; s++) begin
      hi = v.first_hi ^ (s % 2 == 1);
      for (int j = 0; j < segLen(v, s); j++) begin
        if (hi) hp = (j % 2 == 0) ? v.ha : v.hb;
        else    hp = (j % 2 == 0) ? v.la : v.lb;
        if (q.size() == v.bad_idx) hp = v.bad_hp;
        q.push_back(hp);
      end
    end
  endtask

  vec_t vecs[13];
  int   burst[$];
  int   log0;
  bit   m_done, m_err;
  int   m_seg, m_at;
  int   d0, e0;

  initial begin
    vecs[0]  = mk(4, 20, 10, 20, 10, 0, 1, 8, 8, 16, 16, -1, 0, 1, 0, 4, -1, 1);
    vecs[1]  = mk(4, 20, 10, 20, 10, 0, 1, 6, 10, 14, 18, -1, 0, 1, 0, 4, -1, 1);
    vecs[2]  = mk(4, 20, 10, 20, 10, 0, 1, 6, 10, 14, 18, 5, 5, 0, 1, 0, 5, 0);
    vecs[3]  = mk(4, 20, 3, 20, 10, 0, 1, 8, 8, 16, 16, -1, 0, 0, 1, 1, 23, 0);
    vecs[4]  = mk(3, 20, 10, 20, 0, 0, 1, 8, 8, 16, 16, -1, 0, 0, 1, 3, -2, 0);
    vecs[5]  = mk(5, 20, 10, 20, 10, 20, 1, 8, 8, 16, 16, -1, 0, 0, 1, 4, 60, 0);
`ifdef BEEP_DETECT_STRICT_EN
    vecs[6]  = mk(4, 10, 20, 10, 20, 0, 0, 8, 8, 16, 16, -1, 0, 0, 1, 0, 0, 0);
`else
    vecs[6]  = mk(4, 10, 20, 10, 20, 0, 0, 8, 8, 16, 16, -1, 0, 1, 0, 4, -1, 0);
`endif
    vecs[7]  = mk(4, 4, 4, 4, 4, 0, 1, 8, 8, 16, 16, -1, 0, 1, 0, 4, -1, 0);
    vecs[8]  = mk(4, 20, 10, 20, 10, 0, 1, 8, 8, 16, 16, 3, 11, 0, 1, 0, 3, 0);
    vecs[9]  = mk(4, 20, 10, 20, 10, 0, 1, 8, 8, 16, 16, 22, 19, 0, 1, 1, 22, 0);
    vecs[10] = mk(4, 20, 10, 20, 10, 0, 1, 8, 8, 16, 16, 25, 13, 0, 1, 1, 25, 0);
    vecs[11] = mk(1, 20, 0, 0, 0, 0, 1, 8, 8, 16, 16, -1, 0, 0, 1, 1, -2, 0);
    vecs[12] = mk(4, 3, 10, 20, 10, 0, 1, 8, 8, 16, 16, -1, 0, 0, 1, 0, 3, 0);

    rst = 1'b1;
    beep_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    checkOutput("reset tone_active", int'(tone_active), 0);
    checkOutput("reset tone_hi", int'(tone_hi), 0);
    checkOutput("reset seg_cnt", int'(seg_cnt), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset err", int'(err), 0);
    rst = 1'b0;
    repeat (80) @(posedge clk);

    for (int i = 0; i < 13; i++) begin
      buildBurst(vecs[i], burst);
      runBurst($sformatf("vec%0d", i), burst, vecs[i].exp_done, vecs[i].exp_err,
               vecs[i].exp_seg, vecs[i].exp_at, log0);
      if (vecs[i].chk_hi) begin
        checkOutput($sformatf("vec%0d tone_hi_changes", i), hi_log.size() - log0, 4);
        for (int k = 0; k < 4; k++)
          if (hi_log.size() > log0 + k)
            checkOutput($sformatf("vec%0d tone_hi_seg%0d", i, k), hi_log[log0 + k], (k % 2 == 0) ? 1 : 0);
      end
    end

    // Reset during the second segment aborts the burst silently
    buildBurst(vecs[0], burst);
    burst = burst[0:24];
    d0 = done_cnt; e0 = err_cnt;
    tgl.delete();
    applyStimulus(burst);
    repeat (4) @(posedge clk); #2;
    checkOutput("midburst active_before_rst", int'(tone_active), 1);
    checkOutput("midburst seg_before_rst", int'(seg_cnt), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst tone_active", int'(tone_active), 0);
    checkOutput("rst tone_hi", int'(tone_hi), 0);
    checkOutput("rst seg_cnt", int'(seg_cnt), 0);
    checkOutput("rst done", int'(done), 0);
    checkOutput("rst err", int'(err), 0);
    beep_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (150) @(posedge clk); #1;
    checkOutput("rst no_done", done_cnt - d0, 0);
    checkOutput("rst no_err", err_cnt - e0, 0);
    buildBurst(vecs[0], burst);
    runBurst("after_rst", burst, 1'b1, 1'b0, 4, -1, log0);

    // Randomized bursts judged by the reference model
    for (int r = 0; r < 30; r++) begin
      int nseg, len, hp;
      bit cls;
      int bad_vals[5];
      bad_vals = '{5, 11, 13, 19, 25};
      burst.delete();
      nseg = $urandom_range(2, 5);
      cls = 1'($urandom_range(0, 1));
      for (int s = 0; s < nseg; s++) begin
        len = $urandom_range(3, 10);
        for (int j = 0; j < len; j++) begin
          if ($urandom_range(0, 49) == 0) hp = bad_vals[$urandom_range(0, 4)];
          else if (cls) hp = $urandom_range(HI_LOW, HI_HIGH);
          else hp = $urandom_range(LO_LOW, LO_HIGH);
          burst.push_back(hp);
        end
        cls = ~cls;
      end
      judge(burst, m_done, m_err, m_seg, m_at);
      runBurst($sformatf("rnd%0d", r), burst, m_done, m_err, m_seg, m_at, log0);
    end

    checkOutput("done_err_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/beep_detect.md
Name: beep_detect

Overview:
- Receive-side companion to the game's beep generator.
- Samples an incoming beep square wave and measures each half-period.
- Classifies each half-period as the high tone (HI) or the low tone (LO), splits the burst into tone segments, and reports success or failure when the line goes silent.
- Used by the count-game checker to confirm that a beep burst of NUM_SEG alternating tone segments was received.

Parameters:
- HP_HI, 8, nominal HI-tone half-period in clk cycles
- HP_LO, 16, nominal LO-tone half-period in clk cycles
- TOL, 2, allowed deviation (inclusive, ± cycles) for classification
- MIN_SEG_HP, 4, minimum number of half-periods for a valid segment
- SIL_CYC, 64, cycles with no edge that end a burst (must be > HP_LO+TOL)
- NUM_SEG, 4, required segment count per burst (1..7)
- CW, 8, half-period/silence counter width (2^CW > SIL_CYC)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- beep_in  in  1  asynchronous beep line
- tone_active  out  1  high while a burst is being measured
- tone_hi  out  1  class of the current segment (1 = HI, 0 = LO)
- seg_cnt  out  3  segments closed so far in the current burst
- done  out  1  one-cycle pulse: valid burst received
- err  out  1  one-cycle pulse: malformed burst

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared. Reset mid-burst aborts the burst with no done/err pulse.
- Input path: 2-FF synchronizer on beep_in, then an edge detector for any transition. An "edge" below means a detected edge on the synchronized signal (2-cycle latency from the pin).
- hp_cnt clears to 0 on each edge and otherwise increments, saturating at SIL_CYC. hp = hp_cnt value at an edge.
- Classification of hp:
  - HI if HP_HI-TOL <= hp <= HP_HI+TOL
  - LO if HP_LO-TOL <= hp <= HP_LO+TOL
  - otherwise BAD
  - Comparisons are unsigned at CW bits; ranges must not overlap.
- States: IDLE, FIRST, MEAS, DONE, ERR.
- IDLE: on edge -> FIRST, tone_active=1, seg_cnt=0.
- FIRST: waits for the second edge.
  - BAD -> ERR.
  - Otherwise: cur_class=class, seg_hp=1, tone_hi=class -> MEAS.
- MEAS, on edge:
  - BAD -> ERR.
  - class==cur_class: seg_hp++ (saturating).
  - Class change: close the segment. If seg_hp<MIN_SEG_HP -> ERR. Else seg_cnt++; if the new seg_cnt==NUM_SEG -> ERR (extra segment). Else cur_class=class, seg_hp=1, tone_hi=class.
- MEAS, silence: when hp_cnt reaches SIL_CYC, close the segment by the same MIN_SEG_HP rule.
  - seg_cnt (after increment)==NUM_SEG -> DONE.
  - Otherwise -> ERR.
- DONE: done=1 for exactly one cycle (the cycle after hp_cnt reaches SIL_CYC), tone_active=0, then IDLE. seg_cnt holds until the next burst starts.
- ERR: err=1 for one cycle on entry, tone_active=0. Stays in ERR until SIL_CYC cycles pass with no edge (edges restart the wait), then IDLE. Prevents a partial burst from re-arming mid-stream.
- Simultaneous edge and silence threshold cannot occur, because hp_cnt clears on an edge. An edge has priority.
- done and err are never asserted in the same cycle.

Optional Feature:
- Macro BEEP_DETECT_STRICT_EN.
- Defined: the first segment must be HI. A first classified half-period of LO -> ERR.
- Undefined: the first segment may be either class; only alternation (implicit) and segment length/count are checked.

Test Plan:
1. Nominal: 20 hp of 8, 10 of 16, 20 of 8, 10 of 16, then idle -> done pulses once, 64 cycles after the last detected edge +1. seg_cnt=4, err never asserted, tone_hi follows 1,0,1,0.
2. Tolerance edges: repeat 1 with HI hp alternating 6/10 and LO 14/18 -> done. Change one HI hp to 5 -> err pulse at that edge; no done until silence plus a new burst.
3. Short segment: second segment only 3 LO hp -> err at the first HI edge after it, tone_active drops, IDLE after 64 silent cycles.
4. Count errors: 3 valid segments then silence -> err, no done. 5 valid segments -> err at the 5th segment's first edge.
5. Reset mid-burst: assert rst during segment 2 -> all outputs 0 immediately, no pulse. A following nominal burst -> done.
6. Macro: burst starting with LO (10×16, 20×8, 10×16, 20×8) -> err with BEEP_DETECT_STRICT_EN, done without it.
